// File: rtl/lsu_mem_port_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_port_if
//
// Purpose:
//   Data-memory bus between the load/store unit and data memory. The bus has
//   a ready/valid address phase followed by a variable-latency completion
//   phase that is used by both reads and writes.
//
// Signals:
//   bus_valid      LSU -> mem   address phase valid
//   bus_ready      mem -> LSU   address phase accept
//   bus_we         LSU -> mem   write transaction
//   bus_addr       LSU -> mem   doubleword-aligned byte address
//   bus_wdata      LSU -> mem   store data placed on its byte lanes
//   bus_wstrb      LSU -> mem   byte-lane write strobes (zero for reads)
//   bus_rsp_valid  mem -> LSU   completion of the accepted transaction
//   bus_rdata      mem -> LSU   read data, valid with bus_rsp_valid
//
// Modports:
//   master  the load/store unit
//   slave   the data memory
// ---------------------------------------------------------------------------
interface lsu_mem_port_if #(
  parameter int XLEN = 64
);

  logic            bus_valid;
  logic            bus_ready;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic [7:0]      bus_wstrb;
  logic            bus_rsp_valid;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_valid,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_wstrb,
    input  bus_ready,
    input  bus_rsp_valid,
    input  bus_rdata
  );

  modport slave (
    input  bus_valid,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_wstrb,
    output bus_ready,
    output bus_rsp_valid,
    output bus_rdata
  );

endinterface

// File: rtl/lsu_mem_port.sv
// ---------------------------------------------------------------------------
// lsu_mem_port
//
// Purpose:
//   Load/store execution unit. Takes the memory controls from decode (store
//   enable, load enable, unshifted byte mask) plus address and store data,
//   performs the access on the 64-bit data-memory bus and hands load data,
//   aligned and sign/zero extended, back to the write-back path. The core
//   holds off new requests while one is outstanding (req_ready low).
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_req_valid     core presents a memory request
//   o_req_ready     LSU can accept a request (idle only)
//   i_req_wen       store
//   i_req_ren       load
//   i_req_addr      byte address
//   i_req_wdata     store data, right-justified
//   i_req_mask      access size: 01 byte, 03 half, 0f word, ff double
//   i_req_unsigned  zero-extend the load result
//   o_rsp_valid     one-cycle completion pulse
//   o_rsp_rdata     extended load data (zero for stores and errors)
//   o_rsp_err       illegal, misaligned or timed-out access
//   bus             data-memory bus (master side)
// ---------------------------------------------------------------------------
module lsu_mem_port #(
  parameter int XLEN    = 64,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic            i_req_wen,
  input  logic            i_req_ren,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  input  logic [7:0]      i_req_mask,
  input  logic            i_req_unsigned,
  output logic            o_rsp_valid,
  output logic [XLEN-1:0] o_rsp_rdata,
  output logic            o_rsp_err,
  lsu_mem_port_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } LsuState;

  LsuState         r_state;
  LsuState         w_stateNext;

  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [XLEN-1:0]  r_addr;
  logic [2:0]       r_off;
  logic [XLEN-1:0]  r_wdata;
  logic [7:0]       r_wstrb;
  logic [7:0]       r_mask;
  logic             r_unsigned;
  logic             r_err;
  logic [XLEN-1:0]  r_rdata;

  logic             w_maskLegal;
  logic             w_aligned;
  logic             w_reqErr;
  logic             w_cntHit;
  logic             w_capture;
  logic             w_cntClr;
  logic             w_cntInc;
  logic             w_rspDone;
  logic             w_timeoutErr;
  logic             w_busValid;
  logic [XLEN-1:0]  w_rdShift;
  logic [XLEN-1:0]  w_loadData;

  // Request legality: the mask must be one of the four access sizes and the
  // address must be naturally aligned for that size. Bytes are always
  // aligned. An illegal mask is reported through w_maskLegal so the
  // alignment result is don't-care there.
  always_comb begin
    w_maskLegal = 1'b1;
    w_aligned   = 1'b1;
    case (i_req_mask)
      8'h01:   w_aligned = 1'b1;
      8'h03:   w_aligned = (i_req_addr[0] == 1'b0);
      8'h0f:   w_aligned = (i_req_addr[1:0] == 2'b00);
      8'hff:   w_aligned = (i_req_addr[2:0] == 3'b000);
      default: w_maskLegal = 1'b0;
    endcase
  end

  assign w_reqErr = ~(i_req_wen ^ i_req_ren) | ~w_maskLegal | ~w_aligned;

  // The timeout fires on the cycle where the counter would step onto
  // TIMEOUT, so exactly TIMEOUT cycles are spent waiting in ADDR or DATA.
  assign w_cntHit = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register. Reset from any state simply drops the transaction in
  // flight; nothing is reported back to the core for it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state and control decode. The awaited handshake is tested before
  // the timeout so that a handshake landing on the final cycle still
  // completes normally. Completion pulses that arrive outside DATA never
  // reach this decode and are therefore ignored.
  always_comb begin
    w_stateNext  = r_state;
    w_capture    = 1'b0;
    w_cntClr     = 1'b0;
    w_cntInc     = 1'b0;
    w_rspDone    = 1'b0;
    w_timeoutErr = 1'b0;
    w_busValid   = 1'b0;
    o_req_ready  = 1'b0;
    o_rsp_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) begin
          w_capture   = 1'b1;
          w_stateNext = w_reqErr ? RESP : ADDR;
        end
      end
      ADDR: begin
        w_busValid = 1'b1;
        w_cntInc   = 1'b1;
        if (bus.bus_ready) begin
          w_cntClr    = 1'b1;
          w_stateNext = DATA;
        end else if (w_cntHit) begin
          w_timeoutErr = 1'b1;
          w_stateNext  = RESP;
        end
      end
      DATA: begin
        w_cntInc = 1'b1;
        if (bus.bus_rsp_valid) begin
          w_rspDone   = 1'b1;
          w_stateNext = RESP;
        end else if (w_cntHit) begin
          w_timeoutErr = 1'b1;
          w_stateNext  = RESP;
        end
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Wait counter shared by ADDR and DATA. It restarts when a request is
  // accepted and again when the address phase is accepted, so each phase
  // gets its own full timeout budget.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_capture || w_cntClr) begin
      r_cnt <= '0;
    end else if (w_cntInc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Bring the addressed bytes of the returned doubleword down to bit 0,
  // then keep the access size and extend it to the full register width.
  assign w_rdShift = bus.bus_rdata >> {r_off, 3'b000};

  always_comb begin
    w_loadData = w_rdShift;
    case (r_mask)
      8'h01: w_loadData = r_unsigned ? {{(XLEN-8){1'b0}}, w_rdShift[7:0]}
                                     : {{(XLEN-8){w_rdShift[7]}}, w_rdShift[7:0]};
      8'h03: w_loadData = r_unsigned ? {{(XLEN-16){1'b0}}, w_rdShift[15:0]}
                                     : {{(XLEN-16){w_rdShift[15]}}, w_rdShift[15:0]};
      8'h0f: w_loadData = r_unsigned ? {{(XLEN-32){1'b0}}, w_rdShift[31:0]}
                                     : {{(XLEN-32){w_rdShift[31]}}, w_rdShift[31:0]};
      default: w_loadData = w_rdShift;
    endcase
  end

  // Request capture and result registers. Bus-side fields are pre-shifted
  // onto their byte lanes at capture so the address phase drives them
  // straight from flops and they cannot move while waiting for bus_ready.
  // The result is cleared at capture, which leaves zero for stores, errors
  // and timeouts; only a completed load overwrites it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_mask     <= '0;
      r_unsigned <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else if (w_capture) begin
      r_we       <= i_req_wen;
      r_addr     <= {i_req_addr[XLEN-1:3], 3'b000};
      r_off      <= i_req_addr[2:0];
      r_wdata    <= i_req_wdata << {i_req_addr[2:0], 3'b000};
      r_wstrb    <= i_req_wen ? (i_req_mask << i_req_addr[2:0]) : 8'h00;
      r_mask     <= i_req_mask;
      r_unsigned <= i_req_unsigned;
      r_err      <= w_reqErr;
      r_rdata    <= '0;
    end else if (w_timeoutErr) begin
      r_err      <= 1'b1;
    end else if (w_rspDone && !r_we) begin
      r_rdata    <= w_loadData;
    end
  end

  assign bus.bus_valid = w_busValid;
  assign bus.bus_we    = r_we;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_wdata;
  assign bus.bus_wstrb = r_wstrb;

  assign o_rsp_err   = o_rsp_valid & r_err;
  assign o_rsp_rdata = o_rsp_valid ? r_rdata : '0;

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Load/store execution unit that consumes the memory controls produced by instruction decode (write enable, read enable, byte mask) together with address and store data.
- Performs the access on a 64-bit data-memory bus that has a ready/valid address phase and a variable-latency response.
- Returns load data, aligned and sign/zero extended, to the register write-back path.
- Sits between the core datapath and data memory. The core stalls while a request is outstanding.

Parameters:
- XLEN, 64, data and address width.
- TIMEOUT, 255, maximum cycles waited in the ADDR or DATA state before the access is aborted with an error.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  core presents a memory request
- req_ready  out  1  LSU can accept a request (high only in IDLE)
- req_wen  in  1  store
- req_ren  in  1  load
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- req_mask  in  8  access size, unshifted: 8'h01 byte, 8'h03 half, 8'h0f word, 8'hff double
- req_unsigned  in  1  zero-extend load result (lbu/lhu/lwu)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  XLEN  extended load data (0 for stores and errors)
- rsp_err  out  1  qualifies rsp_valid: illegal, misaligned or timed-out access
- bus_valid  out  1  address-phase valid
- bus_ready  in  1  address-phase accept
- bus_we  out  1  write
- bus_addr  out  XLEN  req_addr with bits [2:0] cleared
- bus_wdata  out  XLEN  req_wdata shifted left by 8*addr[2:0]
- bus_wstrb  out  8  req_mask shifted left by addr[2:0] (all zero for reads)
- bus_rsp_valid  in  1  completion of the accepted transaction (reads and writes)
- bus_rdata  in  XLEN  read data, valid with bus_rsp_valid

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE and the counter is 0.
  - Outputs: req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; bus_valid=0; bus_we=0; bus_addr=0; bus_wdata=0; bus_wstrb=0.
  - Reset during any state abandons the transaction; no response is issued.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is captured into registers.
  - Error check: exactly one of wen/ren must be set; mask must be one of the four legal codes; the address must be naturally aligned (half: addr[0]=0; word: addr[1:0]=0; double: addr[2:0]=0).
  - Error -> RESP with err=1, no bus activity.
  - Otherwise -> ADDR.
- ADDR:
  - bus_valid=1.
  - bus_addr, bus_we, bus_wdata and bus_wstrb come from the captured registers and are held stable until bus_ready.
  - On bus_ready -> DATA, counter cleared.
- DATA:
  - bus_valid=0.
  - On bus_rsp_valid -> RESP. For loads, the result is computed and registered as: shift bus_rdata right by 8*addr[2:0], keep the low 8/16/32/64 bits per mask, then sign-extend, or zero-extend if unsigned.
  - bus_rsp_valid seen in any state other than DATA is ignored.
- RESP:
  - rsp_valid=1 for exactly one cycle, then -> IDLE. No backpressure.
  - req_ready=0 in ADDR, DATA and RESP.
- Timeout:
  - The counter increments each cycle in ADDR and in DATA.
  - When it reaches TIMEOUT without the awaited handshake -> RESP with err=1, bus_valid dropped.
  - A bus_rsp_valid or bus_ready arriving in the same cycle as the timeout wins: normal completion.
- Latency:
  - Request accepted at cycle 0.
  - bus_valid at cycle 1.
  - With bus_ready in cycle 1 and bus_rsp_valid in cycle 2, rsp_valid is high in cycle 3.
  - Best case 3 cycles accept-to-response.
- For stores, rsp_rdata=0. For errors, rsp_rdata=0 and rsp_err=1.

Test Plan:
- Doubleword store, addr 0x80000010, wdata 0x1122334455667788, mask 8'hff, bus ready/rsp immediate -> bus_addr 0x80000010, wstrb 8'hff, wdata unchanged; rsp_valid at cycle 3, err=0.
- Byte load lb, addr 0x80000005, bus_rdata 0x0000_8000_0000_0000 -> bus_wstrb 0; rsp_rdata 0xFFFF_FFFF_FFFF_FF80. The same access with req_unsigned=1 -> 0x80.
- Halfword store, addr 0x80000006, wdata 0xABCD -> bus_addr 0x80000000, wstrb 8'hc0, wdata 0xABCD_0000_0000_0000.
- Misaligned word load at 0x80000002, and a request with both wen and ren -> no bus_valid ever; rsp_valid+rsp_err one cycle after accept.
- bus_ready held low for 5 cycles, then rsp after 7 cycles -> bus signals stable throughout, single rsp_valid pulse, err=0. bus_ready never asserted with TIMEOUT=255 -> err response after 255 ADDR cycles.
- rst_n pulsed low while in DATA -> all outputs at reset values immediately; a late bus_rsp_valid is ignored; the next request completes normally.
